// File: rtl/fadd_result_collect.sv
// Collects fadd results on each sum_ready rising edge, classifies them and buffers them in a FWFT FIFO.
// Optional macro FADD_COLLECT_CNT_EN adds a saturating push counter on res_count.
module fadd_result_collect #(
    parameter int N      = 16,
    parameter int EXP_HI = 14,
    parameter int MAN_HI = 6,
    parameter int DEPTH  = 4
) (
    input  logic         clock,
    input  logic         nreset,
    input  logic [N-1:0] sum_in,
    input  logic         sum_ready,
    output logic [N-1:0] out_data,
    output logic [2:0]   out_class,
    output logic         out_valid,
    input  logic         out_ready,
    input  logic         clear_flags,
    output logic         nan_seen,
    output logic         inf_seen,
    output logic         zero_seen,
    output logic         ovf
`ifdef FADD_COLLECT_CNT_EN
    ,
    output logic [7:0]   res_count
`endif
);
    // Handshake: the head entry transfers on any rising clock edge where
    // out_valid and out_ready are both 1; out_data/out_class hold until then.

    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] CLS_ZERO = 3'd0;
    localparam logic [2:0] CLS_SUBN = 3'd1;
    localparam logic [2:0] CLS_NORM = 3'd2;
    localparam logic [2:0] CLS_INF  = 3'd3;
    localparam logic [2:0] CLS_NAN  = 3'd4;

    function automatic logic [2:0] classify(input logic [N-1:0] d);
        logic [EXP_HI-MAN_HI-1:0] e;
        logic [MAN_HI:0]          m;
        e        = d[EXP_HI:MAN_HI+1];
        m        = d[MAN_HI:0];
        classify = CLS_NORM;
        if (d[N-2:0] == '0)
            classify = CLS_ZERO;
        else if (&e)
            classify = (m == '0) ? CLS_INF : CLS_NAN;
        else if (e == '0)
            classify = CLS_SUBN;
    endfunction

    logic            r_rdy_q;
    logic [AW:0]     r_wp;
    logic [AW:0]     r_rp;
    logic [N-1:0]    r_mem_data  [DEPTH];
    logic [2:0]      r_mem_class [DEPTH];
    logic            r_nan;
    logic            r_inf;
    logic            r_zero;
    logic            r_ovf;

    logic            w_capture;
    logic [2:0]      w_class;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_push;

    assign w_capture = sum_ready & ~r_rdy_q;
    assign w_class   = classify(sum_in);
    assign w_empty   = (r_wp == r_rp);
    assign w_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_pop     = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push    = w_capture & (~w_full | w_pop);

    assign out_valid = ~w_empty;
    assign out_data  = w_empty ? '0 : r_mem_data[r_rp[AW-1:0]];
    assign out_class = w_empty ? CLS_ZERO : r_mem_class[r_rp[AW-1:0]];
    assign nan_seen  = r_nan;
    assign inf_seen  = r_inf;
    assign zero_seen = r_zero;
    assign ovf       = r_ovf;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_rdy_q <= 1'b1;
            r_wp    <= '0;
            r_rp    <= '0;
        end else begin
            r_rdy_q <= sum_ready;
            if (w_push)
                r_wp <= r_wp + 1'b1;
            if (w_pop)
                r_rp <= r_rp + 1'b1;
        end
    end

    // Storage needs no reset: the empty flag masks stale contents.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem_data[r_wp[AW-1:0]]  <= sum_in;
            r_mem_class[r_wp[AW-1:0]] <= w_class;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_nan  <= 1'b0;
            r_inf  <= 1'b0;
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_nan  <= (r_nan  & ~clear_flags) | (w_capture && w_class == CLS_NAN);
            r_inf  <= (r_inf  & ~clear_flags) | (w_capture && w_class == CLS_INF);
            r_zero <= (r_zero & ~clear_flags) | (w_capture && w_class == CLS_ZERO);
            r_ovf  <= (r_ovf  & ~clear_flags) | (w_capture & ~w_push);
        end
    end

`ifdef FADD_COLLECT_CNT_EN
    logic [7:0] r_cnt;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_cnt <= 8'd0;
        end else if (clear_flags) begin
            r_cnt <= w_push ? 8'd1 : 8'd0;
        end else if (w_push && r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    assign res_count = r_cnt;
`endif

endmodule

// File: tb/tb_fadd_result_collect.sv
// Scoreboard bench for fadd_result_collect: directed test-plan cases plus randomized traffic vs a queue model.
module tb_fadd_result_collect;

    localparam int N     = 16;
    localparam int DEPTH = 4;

    logic          clock;
    logic          nreset;
    logic [N-1:0]  sum_in;
    logic          sum_ready;
    logic [N-1:0]  out_data;
    logic [2:0]    out_class;
    logic          out_valid;
    logic          out_ready;
    logic          clear_flags;
    logic          nan_seen;
    logic          inf_seen;
    logic          zero_seen;
    logic          ovf;
`ifdef FADD_COLLECT_CNT_EN
    logic [7:0]    res_count;
`endif

    fadd_result_collect #(.N(N), .EXP_HI(14), .MAN_HI(6), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .nreset      (nreset),
        .sum_in      (sum_in),
        .sum_ready   (sum_ready),
        .out_data    (out_data),
        .out_class   (out_class),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .clear_flags (clear_flags),
        .nan_seen    (nan_seen),
        .inf_seen    (inf_seen),
        .zero_seen   (zero_seen),
        .ovf         (ovf)
`ifdef FADD_COLLECT_CNT_EN
        ,
        .res_count   (res_count)
`endif
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: expected entries are {class, data}
    logic [18:0] exp_q[$];
    int          m_cnt;
    logic        m_prev;
    logic        m_nan, m_inf, m_zero, m_ovf;
    int          m_res;

    function automatic logic [2:0] ref_class(input logic [15:0] d);
        int e, m;
        e = (d >> 7) & 'hFF;
        m = d & 'h7F;
        if ((d & 16'h7FFF) == 0) return 3'd0;
        if (e == 255) return (m == 0) ? 3'd3 : 3'd4;
        if (e == 0) return 3'd1;
        return 3'd2;
    endfunction

    always @(posedge clock) begin
        logic       cap, pop, push;
        logic [2:0] c;
        if (!nreset) begin
            exp_q.delete();
            m_cnt = 0; m_prev = 1'b1;
            m_nan = 0; m_inf = 0; m_zero = 0; m_ovf = 0; m_res = 0;
        end else begin
            cap    = sum_ready && !m_prev;
            m_prev = sum_ready;
            pop    = (m_cnt > 0) && out_ready;
            push   = 1'b0;
            if (clear_flags) begin
                m_nan = 0; m_inf = 0; m_zero = 0; m_ovf = 0; m_res = 0;
            end
            if (cap) begin
                c = ref_class(sum_in);
                if (m_cnt < DEPTH || pop) begin
                    exp_q.push_back({c, sum_in});
                    push = 1'b1;
                end else begin
                    m_ovf = 1;
                end
                if (c == 3'd4) m_nan = 1;
                if (c == 3'd3) m_inf = 1;
                if (c == 3'd0) m_zero = 1;
            end
            m_cnt = m_cnt - (pop ? 1 : 0) + (push ? 1 : 0);
            if (push && m_res < 255) m_res++;
        end
    end

    // monitor: checks head, occupancy and flags; pops on accepted transfers
    always @(negedge clock) begin
        if (nreset) begin
            chk("valid", out_valid, exp_q.size() != 0);
            if (out_valid && exp_q.size() != 0) begin
                chk("head_data", out_data, exp_q[0][15:0]);
                chk("head_class", out_class, exp_q[0][18:16]);
                if (out_ready) void'(exp_q.pop_front());
            end else if (!out_valid) begin
                chk("empty_data", out_data, 0);
                chk("empty_class", out_class, 0);
            end
            chk("nan_seen", nan_seen, m_nan);
            chk("inf_seen", inf_seen, m_inf);
            chk("zero_seen", zero_seen, m_zero);
            chk("ovf", ovf, m_ovf);
`ifdef FADD_COLLECT_CNT_EN
            chk("res_count", res_count, m_res);
`endif
        end
    end

    // drivers: inputs change 1 time unit after the rising edge
    task automatic step(input logic rdy, input logic [15:0] d, input logic ordy, input logic clr);
        sum_ready   = rdy;
        sum_in      = d;
        out_ready   = ordy;
        clear_flags = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic capture(input logic [15:0] d, input logic o_low, input logic o_cap);
        step(1'b0, d, o_low, 1'b0);
        step(1'b1, d, o_cap, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 16'h0, 1'b1, 1'b0);
    endtask

    function automatic logic [15:0] rand_val();
        logic [15:0] s;
        s = $urandom_range(1, 0) ? 16'h8000 : 16'h0000;
        case ($urandom_range(4, 0))
            0: return s;
            1: return s | 16'($urandom_range(127, 1));
            2: return s | 16'h7F80;
            3: return s | 16'h7F80 | 16'($urandom_range(127, 1));
            default: return 16'($urandom_range(65535, 0));
        endcase
    endfunction

    initial begin
        nreset = 1'b0; sum_ready = 1'b1; sum_in = 16'h3F80;
        out_ready = 1'b0; clear_flags = 1'b0;
        repeat (3) @(posedge clock);
        #1 nreset = 1'b1;

        // reset release with ready held high: no capture
        repeat (3) step(1'b1, 16'h3F80, 1'b0, 1'b0);
        chk("rst_valid", out_valid, 0);
        chk("rst_flags", {nan_seen, inf_seen, zero_seen, ovf}, 0);

        // single capture, one-cycle latency, then pop
        capture(16'h3F80, 1'b0, 1'b0);
        chk("lat_valid", out_valid, 1);
        chk("lat_data", out_data, 16'h3F80);
        chk("lat_class", out_class, 2);
        step(1'b1, 16'h3F80, 1'b1, 1'b0);
        chk("pop_valid", out_valid, 0);

        // fill FIFO
        capture(16'h7F80, 1'b0, 1'b0);
        capture(16'h7FC0, 1'b0, 1'b0);
        capture(16'h8000, 1'b0, 1'b0);
        capture(16'h0001, 1'b0, 1'b0);
        chk("fill_flags", {nan_seen, inf_seen, zero_seen, ovf}, 4'b1110);
        chk("fill_head", out_class, 3);

        // drop when full, then accept with simultaneous pop
        capture(16'h4000, 1'b0, 1'b0);
        chk("drop_ovf", ovf, 1);
        chk("drop_head", out_data, 16'h7F80);
        capture(16'h4000, 1'b0, 1'b1);
        chk("swap_head", out_data, 16'h7FC0);
        chk("swap_ovf", ovf, 1);
        drain();
        chk("drain_valid", out_valid, 0);

        // clear coinciding with a NAN capture
        step(1'b0, 16'h7FC1, 1'b0, 1'b0);
        step(1'b1, 16'h7FC1, 1'b0, 1'b1);
        chk("clr_flags", {nan_seen, inf_seen, zero_seen, ovf}, 4'b1000);
        drain();

        // randomized traffic
        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(1, 0)), rand_val(), $urandom_range(9, 0) < 6,
                 $urandom_range(99, 0) < 3);
        drain();

        // counter saturation
        for (int i = 0; i < 300; i++) capture(rand_val(), 1'b1, 1'b1);
`ifdef FADD_COLLECT_CNT_EN
        chk("cnt_sat", res_count, 255);
`endif

        // asynchronous reset mid-stream
        capture(16'h3F80, 1'b0, 1'b0);
        capture(16'h4000, 1'b0, 1'b0);
        nreset = 1'b0;
        #1;
        chk("async_valid", out_valid, 0);
`ifdef FADD_COLLECT_CNT_EN
        chk("async_cnt", res_count, 0);
`endif
        sum_ready = 1'b1;
        @(posedge clock);
        #1 nreset = 1'b1;
        repeat (3) step(1'b1, 16'h7F80, 1'b0, 1'b0);
        chk("post_rst_valid", out_valid, 0);
        capture(16'h7F80, 1'b0, 1'b0);
        chk("post_rst_cap", out_data, 16'h7F80);
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
